// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator and checker: states, polynomial codes, tap lookup.
package prbs_pkg;

  localparam int unsigned SR_W  = 23;
  localparam int unsigned TAP_W = 5;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [1:0] POLY_PRBS7  = 2'b00;
  localparam logic [1:0] POLY_PRBS9  = 2'b01;
  localparam logic [1:0] POLY_PRBS15 = 2'b10;
  localparam logic [1:0] POLY_PRBS23 = 2'b11;

  typedef struct packed {
    logic [TAP_W-1:0] n;
    logic [TAP_W-1:0] m;
  } taps_t;

  // Tap pair (N, M) for polynomial x^N + x^M + 1.
  function automatic taps_t poly_taps(input logic [1:0] sel);
    taps_t t;
    case (sel)
      POLY_PRBS7:  t = '{n: 5'd7,  m: 5'd6};
      POLY_PRBS9:  t = '{n: 5'd9,  m: 5'd5};
      POLY_PRBS15: t = '{n: 5'd15, m: 5'd14};
      default:     t = '{n: 5'd23, m: 5'd18};
    endcase
    return t;
  endfunction

  function automatic logic [TAP_W-1:0] poly_len(input logic [1:0] sel);
    taps_t t;
    t = poly_taps(sel);
    return t.n;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// 23-bit receive shift register (sr[0] newest) with tap-selectable prediction.
module prbs_lfsr
  import prbs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       shift_din,
  input  logic [1:0] poly_sel,
  output logic       pred_c,
  output logic       nz_next_c
);

  logic [SR_W-1:0] sr_q, sr_d;
  logic [SR_W-1:0] mask;
  taps_t           taps;

  assign taps   = poly_taps(poly_sel);
  assign mask   = SR_W'((32'h1 << taps.n) - 32'h1);
  assign pred_c = sr_q[taps.n - TAP_W'(1)] ^ sr_q[taps.m - TAP_W'(1)];
  // Low N bits nonzero after shift_din is shifted in (used by the fill check).
  assign nz_next_c = |({sr_q[SR_W-2:0], shift_din} & mask);

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (shift_en) begin
      sr_d = {sr_q[SR_W-2:0], shift_din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker with lock detection, windowed loss-of-lock
// and a saturating error counter.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned VERIFY_BITS = 32,
  parameter int unsigned WIN_BITS    = 64,
  parameter int unsigned LOSS_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [1:0]       poly_sel,
  input  logic             bit_in,
  input  logic             bit_vld,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned VC_W = $clog2(VERIFY_BITS + 1);
  localparam int unsigned WC_W = (WIN_BITS > 1) ? $clog2(WIN_BITS) : 1;
  localparam int unsigned WE_W = $clog2(LOSS_THRESH + 1);

  state_e           state_q, state_d;
  logic [1:0]       poly_q, poly_d;
  logic [TAP_W-1:0] fill_q, fill_d, poly_n;
  logic [VC_W-1:0]  vc_q, vc_d;
  logic [WC_W-1:0]  wc_q, wc_d;
  logic [WE_W-1:0]  we_q, we_d, we_nxt;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             err_pulse_q, err_pulse_d;
  logic             locked_q, locked_d;
  logic             sr_clr_c, sr_shift_c, sr_din_c, pred_c, nz_next_c, mism_c;

  assign poly_n   = poly_len(poly_q);
  // Once locked the register free-runs on its own prediction.
  assign sr_din_c = (state_q == LOCKED) ? pred_c : bit_in;
  assign mism_c   = bit_in ^ pred_c;

  prbs_lfsr u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (sr_clr_c),
    .shift_en  (sr_shift_c),
    .shift_din (sr_din_c),
    .poly_sel  (poly_q),
    .pred_c    (pred_c),
    .nz_next_c (nz_next_c)
  );

  always_comb begin
    state_d     = state_q;
    poly_d      = poly_sel;
    fill_d      = fill_q;
    vc_d        = vc_q;
    wc_d        = wc_q;
    we_d        = we_q;
    we_nxt      = we_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;
    sr_clr_c    = 1'b0;
    sr_shift_c  = 1'b0;

    if (clr || (poly_sel != poly_q)) begin
      state_d  = SEARCH;
      fill_d   = '0;
      vc_d     = '0;
      wc_d     = '0;
      we_d     = '0;
      sr_clr_c = 1'b1;
      if (clr) err_count_d = '0;
    end else if (bit_vld) begin
      sr_shift_c = 1'b1;
      unique case (state_q)
        SEARCH: begin
          fill_d = (fill_q == poly_n) ? fill_q : fill_q + TAP_W'(1);
          if ((fill_d == poly_n) && nz_next_c) begin
            state_d = VERIFY;
            vc_d    = '0;
          end
        end
        VERIFY: begin
          if (mism_c) begin
            state_d = SEARCH;
            fill_d  = '0;
          end else if (vc_q == VC_W'(VERIFY_BITS - 1)) begin
            state_d = LOCKED;
            wc_d    = '0;
            we_d    = '0;
          end else begin
            vc_d = vc_q + VC_W'(1);
          end
        end
        LOCKED: begin
          if (mism_c) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
          end
          we_nxt = we_q + WE_W'(mism_c);
          if (we_nxt == WE_W'(LOSS_THRESH)) begin
            state_d = SEARCH;
            fill_d  = '0;
            wc_d    = '0;
            we_d    = '0;
          end else if (wc_q == WC_W'(WIN_BITS - 1)) begin
            wc_d = '0;
            we_d = '0;
          end else begin
            wc_d = wc_q + WC_W'(1);
            we_d = we_nxt;
          end
        end
        default: begin
          state_d = SEARCH;
          fill_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      poly_q      <= POLY_PRBS7;
      fill_q      <= '0;
      vc_q        <= '0;
      wc_q        <= '0;
      we_q        <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      poly_q      <= poly_d;
      fill_q      <= fill_d;
      vc_q        <= vc_d;
      wc_q        <= wc_d;
      we_q        <= we_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: reference PRBS source, per-polynomial lock table,
// error-pulse scoreboard and hand-written corner sequences.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [1:0]  poly_sel;
  logic        bit_in;
  logic        bit_vld;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        locked2, err_pulse2;
  logic [3:0]  err_count2;

  prbs_checker u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .poly_sel  (poly_sel),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  // Narrow counter, threshold equal to the window: saturation without loss of lock.
  prbs_checker #(.ERR_W(4), .LOSS_THRESH(64)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .poly_sel  (poly_sel),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .locked    (locked2),
    .err_pulse (err_pulse2),
    .err_count (err_count2)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          sb_on = 1'b0;
  int          pulse_seen = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_cnt;
  logic [15:0] sb_e;
  logic [22:0] g_sr;
  int          g_n, g_m;

  typedef struct {
    logic [1:0] poly;
    int         lock_bits;
    logic [15:0] cnt;
  } lock_vec_t;
  lock_vec_t lv[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic gen_seed(input logic [1:0] p);
    case (p)
      2'b00:   begin g_n = 7;  g_m = 6;  end
      2'b01:   begin g_n = 9;  g_m = 5;  end
      2'b10:   begin g_n = 15; g_m = 14; end
      default: begin g_n = 23; g_m = 18; end
    endcase
    g_sr = 23'((64'h1 << g_n) - 64'h1);
  endtask

  task automatic gen_bit(output logic b);
    b    = g_sr[g_n-1] ^ g_sr[g_m-1];
    g_sr = {g_sr[21:0], b};
  endtask

  task automatic drive(input logic b, input logic v);
    @(negedge clk);
    bit_in  = b;
    bit_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen_bit(b);
      drive(b, 1'b1);
    end
  endtask

  // Error on the next stream bit; the expected counter value goes to the scoreboard.
  task automatic inject();
    logic b;
    gen_bit(b);
    exp_cnt = exp_cnt + 16'd1;
    exp_q.push_back(exp_cnt);
    drive(~b, 1'b1);
  endtask

  task automatic lock_bits(input int max, output int nb);
    logic b;
    nb = -1;
    for (int i = 1; i <= max; i++) begin
      gen_bit(b);
      drive(b, 1'b1);
      if (locked === 1'b1) begin
        nb = i;
        break;
      end
    end
  endtask

  task automatic do_reset(input logic [1:0] p);
    @(negedge clk);
    rst_n    = 1'b0;
    clr      = 1'b0;
    bit_vld  = 1'b0;
    bit_in   = 1'b0;
    poly_sel = p;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    exp_cnt = '0;
    gen_seed(p);
  endtask

  // Scoreboard: every err_pulse must match the next expected counter value.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sb_on && err_pulse === 1'b1) begin
      pulse_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected_pulse: got pulse with err_count %0h expected none", err_count);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_err_count", 32'(err_count), 32'(sb_e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   nb, bad, p0;
    logic b;

    lv[0] = '{poly: 2'b00, lock_bits: 39, cnt: 16'd0};
    lv[1] = '{poly: 2'b01, lock_bits: 41, cnt: 16'd0};
    lv[2] = '{poly: 2'b10, lock_bits: 47, cnt: 16'd0};
    lv[3] = '{poly: 2'b11, lock_bits: 55, cnt: 16'd0};

    rst_n = 1'b0; clr = 1'b0; poly_sel = 2'b00; bit_in = 1'b0; bit_vld = 1'b0;
    do_reset(2'b00);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_err_pulse", 32'(err_pulse), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    sb_on = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_reset(lv[i].poly);
      lock_bits(100, nb);
      chk($sformatf("lock_bits_p%0d", i), 32'(nb), 32'(lv[i].lock_bits));
      chk($sformatf("lock_cnt_p%0d", i), 32'(err_count), 32'(lv[i].cnt));
    end

    // Long clean PRBS7 run.
    do_reset(2'b00);
    lock_bits(100, nb);
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      gen_bit(b);
      drive(b, 1'b1);
      if (locked !== 1'b1) bad++;
    end
    chk("prbs7_unlocked_samples", 32'(bad), 32'd0);
    chk("prbs7_err_count", 32'(err_count), 32'd0);

    // PRBS15: three isolated errors.
    do_reset(2'b10);
    lock_bits(100, nb);
    p0 = pulse_seen;
    for (int k = 0; k < 3; k++) begin
      send_clean(99);
      inject();
    end
    send_clean(50);
    chk("prbs15_pulses", 32'(pulse_seen - p0), 32'd3);
    chk("prbs15_err_count", 32'(err_count), 32'd3);
    chk("prbs15_locked", 32'(locked), 32'd1);

    // PRBS9: eight errors in one window drop lock, then relock.
    do_reset(2'b01);
    lock_bits(100, nb);
    for (int k = 1; k <= 8; k++) begin
      inject();
      if (k == 7) chk("prbs9_locked_after7", 32'(locked), 32'd1);
      if (k < 8) send_clean(1);
    end
    chk("prbs9_lock_fall", 32'(locked), 32'd0);
    lock_bits(100, nb);
    chk("prbs9_relock_bits", 32'(nb), 32'd41);
    chk("prbs9_err_count_kept", 32'(err_count), 32'd8);

    // All-zero input never locks.
    do_reset(2'b00);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, 1'b1);
      if (locked !== 1'b0) bad++;
    end
    chk("zeros_never_lock", 32'(bad), 32'd0);
    chk("zeros_err_count", 32'(err_count), 32'd0);

    // Saturation on the narrow-counter instance, errors spanning two windows.
    sb_on = 1'b0;
    do_reset(2'b00);
    lock_bits(100, nb);
    chk("sat_locked", 32'(locked2), 32'd1);
    for (int k = 0; k < 14; k++) begin
      send_clean(3);
      gen_bit(b);
      drive(~b, 1'b1);
    end
    chk("sat_count_e", 32'(err_count2), 32'hE);
    for (int k = 0; k < 5; k++) begin
      send_clean(3);
      gen_bit(b);
      drive(~b, 1'b1);
    end
    chk("sat_count_f", 32'(err_count2), 32'hF);
    chk("sat_still_locked", 32'(locked2), 32'd1);

    // PRBS23: poly change, clr with a valid bit, async reset.
    do_reset(2'b11);
    sb_on = 1'b1;
    lock_bits(100, nb);
    chk("prbs23_lock_bits", 32'(nb), 32'd55);
    inject();
    send_clean(2);
    chk("prbs23_err_count", 32'(err_count), 32'd1);
    @(negedge clk);
    poly_sel = 2'b00;
    bit_vld  = 1'b0;
    @(posedge clk);
    #1;
    chk("poly_change_unlock", 32'(locked), 32'd0);
    chk("poly_change_cnt_kept", 32'(err_count), 32'd1);
    gen_seed(2'b00);
    gen_bit(b);
    @(negedge clk);
    clr     = 1'b1;
    bit_in  = b;
    bit_vld = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    exp_cnt = '0;
    chk("clr_err_count", 32'(err_count), 32'd0);
    lock_bits(100, nb);
    chk("clr_bit_ignored", 32'(nb), 32'd39);

    sb_on = 1'b0;
    gen_bit(b);
    drive(~b, 1'b1);
    chk("pre_rst_pulse", 32'(err_pulse), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_locked", 32'(locked), 32'd0);
    chk("async_rst_pulse", 32'(err_pulse), 32'd0);
    chk("async_rst_count", 32'(err_count), 32'd0);
    @(negedge clk);
    bit_vld = 1'b0;
    rst_n   = 1'b1;
    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial PRBS checker that sits directly downstream of the PRBS generator stage and consumes its bit stream, either looped back on-chip or returned through a pad. It self-synchronises to one of four selectable polynomials and declares lock after a verification run. While locked it counts bit errors in a saturating counter and drops lock when the error density exceeds a threshold.

## Interface
Parameters:
- ERR_W, 16: width of the saturating error counter.
- VERIFY_BITS, 32: consecutive correct bits required in VERIFY before lock.
- WIN_BITS, 64: length in valid bits of the loss-of-lock window.
- LOSS_THRESH, 8: errors within one window that force loss of lock (1..WIN_BITS).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear: err_count to 0, state to SEARCH.
- poly_sel  in  2  polynomial: 00 PRBS7 (x^7+x^6+1), 01 PRBS9 (x^9+x^5+1), 10 PRBS15 (x^15+x^14+1), 11 PRBS23 (x^23+x^18+1).
- bit_in  in  1  received bit, qualified by bit_vld.
- bit_vld  in  1  bit_in is valid this cycle. There is no backpressure; every valid bit is consumed.
- locked  out  1  high in LOCKED state.
- err_pulse  out  1  one-cycle pulse per counted error.
- err_count  out  ERR_W  saturating count of errors seen while LOCKED.

## Operation
- Sequence definition, matching the generator: b[n] = b[n-N] ^ b[n-M] for polynomial x^N+x^M+1. The 23-bit shift register sr has sr[0] = newest bit. Prediction p = sr[N-1] ^ sr[M-1].
- SEARCH: each valid bit shifts into sr. A fill counter counts to N.
  - When the count reaches N and sr[N-1:0] is nonzero, go to VERIFY.
  - If sr[N-1:0] is all zero, stay in SEARCH with the counter held at N and keep shifting.
- VERIFY: each valid bit is compared against p, and the received bit shifts into sr.
  - A mismatch returns to SEARCH with the fill counter at 0.
  - VERIFY_BITS consecutive matches go to LOCKED.
  - No errors are counted in this state.
- LOCKED: sr free-runs by shifting in p, not bit_in, so a single errored bit counts once.
  - A mismatch (bit_in != p) produces an error: err_pulse fires and err_count increments, saturating at 2^ERR_W-1.
  - Window counter wc counts 0..WIN_BITS-1 over valid bits; window error counter we counts errors in the current window.
  - When we reaches LOSS_THRESH, go to SEARCH (fill 0); err_count is kept.
  - On the last bit of a window, that bit's error is counted in the window before wc and we reset to 0.
- Any change of poly_sel (compared with a registered copy) forces SEARCH with fill 0. err_count is kept.
- clr has priority over bit_vld in the same cycle; that bit is discarded.
- bit_vld low: no state, counter or sr change. err_pulse is 0.

## Timing
- Reset values: locked=0, err_pulse=0, err_count=0, state SEARCH, sr=0, all counters 0, registered poly_sel=00.
- All outputs are registered.
- err_pulse and the err_count increment appear the cycle after the bit_vld cycle carrying the errored bit.
- locked rises the cycle after the VERIFY_BITS-th matching valid bit.
- locked falls the cycle after the bit that brings we to LOSS_THRESH.
- Minimum lock time from reset with back-to-back valid bits is N + VERIFY_BITS valid cycles.
- rst_n asserted mid-operation clears everything immediately, regardless of clk.

## Structure
- prbs_pkg holds:
  - the state enum (SEARCH, VERIFY, LOCKED);
  - the poly_sel codes;
  - a function returning the tap pair (N, M) for a code.
- The generator stage shares prbs_pkg.
- One sub-module, prbs_lfsr: a 23-bit shift register with tap-selectable prediction.
  - Inputs: shift enable, shift data, clear.
  - Output: prediction p.
- The checker FSM, fill/verify/window counters and error counter live in prbs_checker.

## Test plan
- PRBS7 stream from a reference model, seed 7'h7F, continuous valid → locked rises after 7+32=39 bits; err_count stays 0 over 10,000 bits.
- Locked on PRBS15, flip 3 isolated bits spaced 100 bits apart → exactly 3 err_pulse, err_count=3, locked stays 1.
- Locked on PRBS9, invert 8 bits within one 64-bit window → locked falls after the 8th error; relock after 9+32 clean bits; err_count=8 retained.
- All-zero input for 200 bits → remains in SEARCH, locked never asserts.
- Force err_count to 16'hFFFE via errors spanning windows (LOSS_THRESH=WIN_BITS), inject 5 more errors → err_count saturates at 16'hFFFF.
- While locked on PRBS23: change poly_sel to 00 → locked drops next cycle. Assert clr together with bit_vld → err_count=0 and the bit is ignored. Pulse rst_n mid-stream → all outputs 0 asynchronously.
